// File: rtl/stream_ram_loader.sv
// Byte-stream to RAM image loader: packs bytes into DATA_W-bit words, writes them
// from BASE_ADDR upward, optionally reads each word back and flags the first mismatch.
module stream_ram_loader #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0,
  parameter bit                   BIG_ENDIAN = 1'b0,
  parameter int unsigned          WR_CYCLES  = 2,
  parameter int unsigned          RD_LATENCY = 1,
  parameter bit                   VERIFY     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_input,
  input  logic [DATA_W-1:0] data_output,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] words_written
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned IDX_W   = $clog2(NB + 1);
  localparam int unsigned CNT_MAX = (WR_CYCLES > RD_LATENCY) ? WR_CYCLES : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_READ, S_ADVANCE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, lane;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] word;
  logic              last_word;
  logic              accept, word_end, wr_done, rd_done;

  assign accept     = (state == S_COLLECT) && byte_valid;
  assign word_end   = accept && (byte_last || (idx == IDX_W'(NB - 1)));
  assign wr_done    = (cnt == CNT_W'(WR_CYCLES - 1));
  assign rd_done    = (cnt == CNT_W'(RD_LATENCY - 1));
  assign lane       = BIG_ENDIAN ? (IDX_W'(NB - 1) - idx) : idx;
  assign data_input = word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Strobes decode straight from the state register so reset drops them at once.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    cs         = 1'b0;
    we         = 1'b0;
    oe         = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        if (word_end) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        cs = 1'b1;
        we = 1'b1;
        if (wr_done) state_nxt = VERIFY ? S_READ : S_ADVANCE;
      end
      S_READ: begin
        cs = 1'b1;
        oe = 1'b1;
        if (rd_done) state_nxt = S_ADVANCE;
      end
      S_ADVANCE: state_nxt = last_word ? S_DONE : S_COLLECT;
      S_DONE: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address       <= '0;
      err_addr      <= '0;
      words_written <= '0;
      finished      <= 1'b0;
      error         <= 1'b0;
      idx           <= '0;
      cnt           <= '0;
      word          <= '0;
      last_word     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            finished      <= 1'b0;
            error         <= 1'b0;
            err_addr      <= '0;
            words_written <= '0;
            address       <= BASE_ADDR;
            idx           <= '0;
            cnt           <= '0;
            word          <= '0;
            last_word     <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            word[{lane, 3'b000} +: 8] <= byte_data;
            idx                       <= idx + IDX_W'(1);
            if (word_end) last_word   <= byte_last;
          end
        end
        S_WRITE: cnt <= wr_done ? '0 : cnt + CNT_W'(1);
        S_READ: begin
          if (rd_done) begin
            cnt <= '0;
            // Only the first mismatching word is recorded.
            if ((data_output != word) && !error) begin
              error    <= 1'b1;
              err_addr <= address;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ADVANCE: begin
          words_written <= words_written + ADDR_W'(1);
          address       <= address + ADDR_W'(NB);
          idx           <= '0;
          word          <= '0;
          if (last_word) finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_ram_loader.sv
// Bench for stream_ram_loader: two instances (default little-endian, and big-endian at
// 0x100 with slower RAM timing) driving a behavioural RAM, checked against a byte-level model.
module tb_stream_ram_loader;

  typedef logic [7:0] bq_t[$];
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic        clk, rst_n;
  logic [1:0]  start, byte_valid, byte_last, byte_ready;
  logic [1:0]  cs, we, oe, busy, finished, error;
  logic [7:0]  byte_data     [2];
  logic [31:0] address       [2];
  logic [31:0] data_input    [2];
  logic [31:0] data_output   [2];
  logic [31:0] err_addr      [2];
  logic [31:0] words_written [2];

  logic [31:0] mem [2][256];
  logic [1:0]  mem_clr;
  logic        stuck_en;
  int          tests, fails, viol;

  stream_ram_loader dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .byte_data(byte_data[0]),
    .byte_valid(byte_valid[0]), .byte_last(byte_last[0]), .byte_ready(byte_ready[0]),
    .address(address[0]), .data_input(data_input[0]), .data_output(data_output[0]),
    .cs(cs[0]), .we(we[0]), .oe(oe[0]), .busy(busy[0]), .finished(finished[0]),
    .error(error[0]), .err_addr(err_addr[0]), .words_written(words_written[0])
  );

  stream_ram_loader #(
    .BASE_ADDR(32'h100), .BIG_ENDIAN(1'b1), .WR_CYCLES(3), .RD_LATENCY(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .byte_data(byte_data[1]),
    .byte_valid(byte_valid[1]), .byte_last(byte_last[1]), .byte_ready(byte_ready[1]),
    .address(address[1]), .data_input(data_input[1]), .data_output(data_output[1]),
    .cs(cs[1]), .we(we[1]), .oe(oe[1]), .busy(busy[1]), .finished(finished[1]),
    .error(error[1]), .err_addr(err_addr[1]), .words_written(words_written[1])
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, read data valid throughout oe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr[k]) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= FILL;
      end else if (cs[k] && we[k]) begin
        mem[k][address[k][9:2]] <= data_input[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      data_output[k] = '0;
      if (oe[k]) begin
        data_output[k] = mem[k][address[k][9:2]];
        if (k == 0 && stuck_en && address[k] == 32'd4) data_output[k][0] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && oe[k]) viol++;
        if (byte_ready[k] && cs[k]) viol++;
      end
    end
  end

  // Reference: word i is bytes 4i..4i+3, zero padded, placed by byte order.
  function automatic logic [31:0] model_word(input bq_t q, input int i, input bit be);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      if (4 * i + j < q.size()) w |= {24'h0, q[4 * i + j]} << (be ? 8 * (3 - j) : 8 * j);
    end
    return w;
  endfunction

  task automatic clear_mem(input int k);
    @(negedge clk); mem_clr[k] = 1'b1;
    @(negedge clk); mem_clr[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input bit last, input int max_gap);
    int t;
    byte_valid[k] = 1'b0;
    repeat (max_gap > 0 ? $urandom_range(max_gap, 0) : 0) @(negedge clk);
    byte_data[k] = b; byte_last[k] = last; byte_valid[k] = 1'b1;
    t = 0;
    while (!byte_ready[k] && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      tests++; fails++;
      $display("FAIL byte_ready_timeout inst=%0d got=0 want=1", k);
    end
    @(negedge clk);
    byte_valid[k] = 1'b0; byte_last[k] = 1'b0;
  endtask

  task automatic run_load(input int k, input bq_t q, input int max_gap, input bit poke_start);
    int t;
    pulse_start(k);
    foreach (q[i]) begin
      if (poke_start && i == 2) start[k] = 1'b1;
      send_byte(k, q[i], i == q.size() - 1, max_gap);
      start[k] = 1'b0;
    end
    t = 0;
    while (!finished[k] && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      tests++; fails++;
      $display("FAIL finished_timeout inst=%0d got=0 want=1", k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({cs[k], we[k], oe[k], byte_ready[k], busy[k], finished[k], error[k]} !== 7'b0) begin
        fails++; $display("FAIL reset_flags inst=%0d got=%b want=0", k,
          {cs[k], we[k], oe[k], byte_ready[k], busy[k], finished[k], error[k]});
      end
      tests++;
      if (address[k] !== 32'd0) begin fails++; $display("FAIL reset_address got=%h want=0", address[k]); end
      tests++;
      if (words_written[k] !== 32'd0) begin fails++; $display("FAIL reset_ww got=%h want=0", words_written[k]); end
      tests++;
      if (err_addr[k] !== 32'd0) begin fails++; $display("FAIL reset_err_addr got=%h want=0", err_addr[k]); end
      tests++;
      if (data_input[k] !== 32'd0) begin fails++; $display("FAIL reset_data_input got=%h want=0", data_input[k]); end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_little_endian();
    bq_t q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_mem(0);
    run_load(0, q, 0, 1'b1);
    tests++;
    if (mem[0][0] !== 32'h44332211) begin fails++; $display("FAIL le_word0 got=%h want=44332211", mem[0][0]); end
    tests++;
    if (mem[0][1] !== 32'h88776655) begin fails++; $display("FAIL le_word1 got=%h want=88776655", mem[0][1]); end
    tests++;
    if (mem[0][2] !== FILL) begin fails++; $display("FAIL le_no_pad_word got=%h want=%h", mem[0][2], FILL); end
    tests++;
    if (words_written[0] !== 32'd2) begin fails++; $display("FAIL le_ww got=%0d want=2", words_written[0]); end
    tests++;
    if ({finished[0], error[0], busy[0]} !== 3'b100) begin
      fails++; $display("FAIL le_status got=%b want=100", {finished[0], error[0], busy[0]});
    end
  endtask

  task automatic test_big_endian();
    bq_t q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_mem(1);
    run_load(1, q, 5, 1'b0);
    tests++;
    if (mem[1][64] !== 32'h11223344) begin fails++; $display("FAIL be_word0 got=%h want=11223344", mem[1][64]); end
    tests++;
    if (mem[1][65] !== 32'h55667788) begin fails++; $display("FAIL be_word1 got=%h want=55667788", mem[1][65]); end
    tests++;
    if (words_written[1] !== 32'd2) begin fails++; $display("FAIL be_ww got=%0d want=2", words_written[1]); end
  endtask

  task automatic test_partial();
    bq_t q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    clear_mem(0);
    run_load(0, q, 2, 1'b0);
    tests++;
    if (mem[0][0] !== 32'hA4A3A2A1) begin fails++; $display("FAIL part_word0 got=%h want=a4a3a2a1", mem[0][0]); end
    tests++;
    if (mem[0][1] !== 32'h000000A5) begin fails++; $display("FAIL part_word1 got=%h want=000000a5", mem[0][1]); end
    tests++;
    if (words_written[0] !== 32'd2) begin fails++; $display("FAIL part_ww got=%0d want=2", words_written[0]); end
  endtask

  task automatic test_verify_mismatch();
    bq_t q;
    for (int i = 0; i < 12; i++) q.push_back(8'h00);
    clear_mem(0);
    stuck_en = 1'b1;
    run_load(0, q, 0, 1'b0);
    stuck_en = 1'b0;
    tests++;
    if (error[0] !== 1'b1) begin fails++; $display("FAIL vfy_error got=%b want=1", error[0]); end
    tests++;
    if (err_addr[0] !== 32'd4) begin fails++; $display("FAIL vfy_err_addr got=%h want=4", err_addr[0]); end
    tests++;
    if (finished[0] !== 1'b1) begin fails++; $display("FAIL vfy_finished got=%b want=1", finished[0]); end
    tests++;
    if (words_written[0] !== 32'd3) begin fails++; $display("FAIL vfy_ww got=%0d want=3", words_written[0]); end
  endtask

  task automatic test_random_backpressure();
    for (int r = 0; r < 3; r++) begin
      bq_t q;
      int n, nw;
      n  = $urandom_range(20, 1);
      nw = (n + 3) / 4;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      clear_mem(1);
      run_load(1, q, 5, 1'b0);
      for (int i = 0; i < nw; i++) begin
        tests++;
        if (mem[1][64 + i] !== model_word(q, i, 1'b1)) begin
          fails++; $display("FAIL rnd_word r=%0d i=%0d got=%h want=%h", r, i, mem[1][64 + i], model_word(q, i, 1'b1));
        end
      end
      tests++;
      if (mem[1][64 + nw] !== FILL) begin fails++; $display("FAIL rnd_overrun r=%0d got=%h want=%h", r, mem[1][64 + nw], FILL); end
      tests++;
      if (words_written[1] !== 32'(nw)) begin fails++; $display("FAIL rnd_ww r=%0d got=%0d want=%0d", r, words_written[1], nw); end
      tests++;
      if (error[1] !== 1'b0) begin fails++; $display("FAIL rnd_error r=%0d got=1 want=0", r); end
    end
  endtask

  task automatic test_reset_mid_write();
    bq_t q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    clear_mem(0);
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'hC1 + 8'(i), 1'b0, 0);
    @(posedge clk); #1;
    tests++;
    if ({cs[0], we[0]} !== 2'b11) begin fails++; $display("FAIL mid_in_write got=%b want=11", {cs[0], we[0]}); end
    rst_n = 1'b0; #1;
    tests++;
    if ({cs[0], we[0], oe[0], busy[0], byte_ready[0]} !== 5'b0) begin
      fails++; $display("FAIL mid_strobes got=%b want=0", {cs[0], we[0], oe[0], busy[0], byte_ready[0]});
    end
    tests++;
    if ({address[0], words_written[0], data_input[0]} !== 96'b0) begin
      fails++; $display("FAIL mid_regs got=%h/%h/%h want=0", address[0], words_written[0], data_input[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (mem[0][1] !== FILL) begin fails++; $display("FAIL mid_stray_write got=%h want=%h", mem[0][1], FILL); end
    run_load(0, q, 1, 1'b0);
    tests++;
    if (mem[0][0] !== 32'h04030201) begin fails++; $display("FAIL mid_reload0 got=%h want=04030201", mem[0][0]); end
    tests++;
    if (mem[0][1] !== 32'h08070605) begin fails++; $display("FAIL mid_reload1 got=%h want=08070605", mem[0][1]); end
    tests++;
    if (words_written[0] !== 32'd2) begin fails++; $display("FAIL mid_ww got=%0d want=2", words_written[0]); end
  endtask

  task automatic test_protocol();
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL protocol_violations got=%0d want=0", viol); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    start = '0; byte_valid = '0; byte_last = '0; mem_clr = '0; stuck_en = 1'b0;
    byte_data[0] = '0; byte_data[1] = '0;
    tests = 0; fails = 0; viol = 0;
    test_reset();
    test_little_endian();
    test_big_endian();
    test_partial();
    test_verify_mismatch();
    test_random_backpressure();
    test_reset_mid_write();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
